uart_modem_ctrl: RTL
====================

# uart_modem_ctrl

Modem-control and flow-control sequencer for the APB UART. Synchronizes the asynchronous modem inputs (nCTS, nDSR, nDCD, nRI) and maintains the modem status register with delta/edge flags and interrupt. Drives the modem outputs (nRTS, nDTR, OUT1, OUT2) from the modem control register, with internal loopback. Schedules the transmitter's character starts against CTS, and throttles RTS from the RX FIFO fill level.

## Interface
- FIFO_AW, 4, RX FIFO address width; level ports are FIFO_AW+1 bits (depth 16).
- SYNC_STAGES, 2, flops per modem-input synchronizer (legal 2..4).

- clk  in  1  UART core clock
- rst_n  in  1  asynchronous active-low reset
- nCTS, nDSR, nDCD, nRI  in  1 each  asynchronous modem inputs, active low
- nRTS, nDTR, OUT1, OUT2  out  1 each  registered modem outputs, active low
- mcr_wr  in  1  MCR write strobe
- mcr_wdata  in  6  [0]DTR [1]RTS [2]OUT1 [3]OUT2 [4]LOOP [5]AFE
- mcr  out  6  current MCR contents
- msr_rd  in  1  MSR read strobe; clears delta bits
- msr  out  8  [0]DCTS [1]DDSR [2]TERI [3]DDCD [4]CTS [5]DSR [6]RI [7]DCD
- ier_msi  in  1  modem-status interrupt enable
- modem_irq  out  1  registered interrupt: ier_msi & |msr[3:0]
- rx_fifo_level  in  FIFO_AW+1  current RX FIFO occupancy
- rx_trig  in  FIFO_AW+1  auto-RTS deassert threshold
- tx_req  in  1  transmitter has a character ready (level)
- tx_gnt  out  1  one-cycle permission to start the character

## Operation
- Synchronizers reset to 1 (inactive). Status bits: CTS=~sync(nCTS), DSR=~sync(nDSR), RI=~sync(nRI), DCD=~sync(nDCD).
- LOOP=1: all four output pins forced to 1. Status sources become CTS=MCR.RTS, DSR=MCR.DTR, RI=MCR.OUT1, DCD=MCR.OUT2. External inputs are ignored.
- Delta bits use registered previous status:
  - DCTS/DDSR/DDCD set on any change.
  - TERI set only on RI 1→0.
  - Bits are sticky until msr_rd.
- msr_rd coincident with a new delta event: the bit stays set (set wins).
- Entering or leaving LOOP may cause a status change. The resulting deltas are recorded normally.
- Pins (LOOP=0): nDTR=~DTR, OUT1=~MCR.OUT1, OUT2=~MCR.OUT2, nRTS=~(RTS & rts_ok).
- rts_ok FSM, states RTS_ON/RTS_OFF, reset RTS_ON:
  - RTS_ON→RTS_OFF when AFE & rx_fifo_level >= max(rx_trig,1).
  - RTS_OFF→RTS_ON when rx_fifo_level == 0.
  - AFE=0 forces RTS_ON.
- TX FSM, states IDLE/HOLD/GNT/WAIT, reset IDLE:
  - IDLE: on tx_req go to GNT if cts_ok, else to HOLD.
  - HOLD→GNT when cts_ok.
  - GNT asserts tx_gnt for exactly one cycle, then goes to WAIT.
  - WAIT→IDLE when tx_req=0.
  - cts_ok = ~AFE | CTS.
  - tx_req dropping while in HOLD returns the FSM to IDLE with no grant.
- CTS deasserting after a grant never aborts the character in flight. It only blocks the next grant.

## Timing
- Reset values: nRTS=nDTR=OUT1=OUT2=1, mcr=0, msr=0, modem_irq=0, tx_gnt=0.
- Pin edge → msr status bit and delta: SYNC_STAGES+1 cycles. modem_irq follows one cycle later.
- mcr_wr → pins and mcr: 1 cycle. LOOP status path: 2 cycles (MCR reg + status reg).
- rx_fifo_level crossing → nRTS change: 1 cycle (FSM reg); pin is combinational from FSM state and MCR.
- tx_req rise with cts_ok → tx_gnt high: 2 cycles (IDLE→GNT, gnt registered from state).
- msr_rd → deltas 0 and modem_irq low: 1 and 2 cycles respectively.
- Asynchronous reset mid-grant or mid-HOLD: FSMs return to IDLE/RTS_ON immediately; tx_gnt drops without a completing pulse.

## Configuration
- UART_AUTO_FLOW_EN defined: AFE bit functional, rts_ok FSM and CTS gating compiled in.
- Undefined:
  - mcr[5] reads 0 and writes are ignored.
  - rts_ok is constant 1.
  - cts_ok is constant 1, so the TX FSM never enters HOLD. Grant latency is unchanged.
  - rx_fifo_level and rx_trig are unused.

## Test plan
- Reset, then hold all pins high → msr=8'h00, nRTS=nDTR=OUT1=OUT2=1, modem_irq=0 throughout.
- ier_msi=1, drive nCTS 1→0 → after 3 cycles msr=8'h11; modem_irq=1 next cycle. msr_rd → msr=8'h10, modem_irq=0.
- nRI 0→1 with a simultaneous msr_rd on the TERI-setting cycle → msr[2]=1 remains set.
- Write mcr=6'h1F (LOOP, all outputs on) → pins all 1, msr[7:4]=4'hF after 2 cycles, deltas 4'hB (CTS, DSR, DCD changed; RI rose, so TERI=0).
- UART_AUTO_FLOW_EN, mcr=6'h22, rx_trig=8:
  - level 7→8 → nRTS 0→1 next cycle.
  - level 8→3 → nRTS stays 1.
  - level →0 → nRTS 0.
- AFE=1, nCTS=1, raise tx_req → no tx_gnt for 20 cycles. Drop nCTS → a single tx_gnt pulse. Raise nCTS during WAIT → no abort, and the next tx_req is held.

Source files
------------

// File: rtl/uart_modem_ctrl.sv
// Modem-control / flow-control sequencer for the APB UART: modem input sync, MSR deltas and IRQ,
// MCR-driven pins with loopback, CTS-gated TX grants and RX-level RTS throttling (UART_AUTO_FLOW_EN).
module uart_modem_ctrl #(
  parameter int FIFO_AW     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               nCTS,
  input  logic               nDSR,
  input  logic               nDCD,
  input  logic               nRI,
  output logic               nRTS,
  output logic               nDTR,
  output logic               OUT1,
  output logic               OUT2,
  input  logic               mcr_wr,
  input  logic [5:0]         mcr_wdata,
  output logic [5:0]         mcr,
  input  logic               msr_rd,
  output logic [7:0]         msr,
  input  logic               ier_msi,
  output logic               modem_irq,
  input  logic [FIFO_AW:0]   rx_fifo_level,
  input  logic [FIFO_AW:0]   rx_trig,
  input  logic               tx_req,
  output logic               tx_gnt
);

`ifdef UART_AUTO_FLOW_EN
  localparam logic [5:0] MCR_MASK = 6'h3F;
`else
  localparam logic [5:0] MCR_MASK = 6'h1F;
`endif

  typedef enum logic [1:0] {TX_IDLE, TX_HOLD, TX_GNT, TX_WAIT} tx_state_t;

  // Bit order throughout the status path: {DCD, RI, DSR, CTS}
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [5:0] mcr_q;
  logic [3:0] stat_q;
  logic [3:0] delta_q;
  logic [3:0] stat_src;
  logic [3:0] delta_ev;
  logic [3:0] delta_d;
  logic       irq_q;
  logic       dtr, rts, out1, out2, loop;
  logic       rts_ok;
  logic       cts_ok;
  tx_state_t  tx_q, tx_d;
  logic       gnt_q;

  assign dtr  = mcr_q[0];
  assign rts  = mcr_q[1];
  assign out1 = mcr_q[2];
  assign out2 = mcr_q[3];
  assign loop = mcr_q[4];

  // Input synchronizers; reset to the inactive (high) level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {nDCD, nRI, nDSR, nCTS}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcr_q <= '0;
    end else if (mcr_wr) begin
      mcr_q <= mcr_wdata & MCR_MASK;
    end
  end

  // Loopback feeds the status bits from the MCR outputs instead of the pins
  assign stat_src = loop ? {out2, out1, dtr, rts} : ~sync_q[SYNC_STAGES-1];

  assign delta_ev = {stat_q[3] ^ stat_src[3],
                     stat_q[2] & ~stat_src[2],
                     stat_q[1] ^ stat_src[1],
                     stat_q[0] ^ stat_src[0]};

  // A new event on the read cycle keeps its delta bit set
  assign delta_d = delta_ev | (delta_q & ~{4{msr_rd}});

  // Status / delta stage boundary, IRQ one stage behind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q  <= '0;
      delta_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      stat_q  <= stat_src;
      delta_q <= delta_d;
      irq_q   <= ier_msi & (|delta_q);
    end
  end

`ifdef UART_AUTO_FLOW_EN
  typedef enum logic {RTS_ON = 1'b0, RTS_OFF = 1'b1} rts_state_t;

  rts_state_t         rts_q, rts_d;
  logic               afe;
  logic [FIFO_AW:0]   rts_thr;

  assign afe     = mcr_q[5];
  // A zero trigger would throttle an empty FIFO forever, so clamp it to one
  assign rts_thr = (rx_trig == '0) ? {{FIFO_AW{1'b0}}, 1'b1} : rx_trig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rts_q <= RTS_ON;
    end else begin
      rts_q <= rts_d;
    end
  end

  always_comb begin
    rts_d = rts_q;
    if (!afe) begin
      rts_d = RTS_ON;
    end else begin
      case (rts_q)
        RTS_ON:  if (rx_fifo_level >= rts_thr) rts_d = RTS_OFF;
        RTS_OFF: if (rx_fifo_level == '0)      rts_d = RTS_ON;
        default: rts_d = RTS_ON;
      endcase
    end
  end

  assign rts_ok = (rts_q == RTS_ON);
  assign cts_ok = ~afe | stat_q[0];
`else
  logic unused_fifo;

  assign unused_fifo = ^{rx_fifo_level, rx_trig};
  assign rts_ok      = 1'b1;
  assign cts_ok      = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q  <= TX_IDLE;
      gnt_q <= 1'b0;
    end else begin
      tx_q  <= tx_d;
      gnt_q <= (tx_q == TX_GNT);
    end
  end

  // CTS only gates the start of a character; once granted, WAIT ignores it
  always_comb begin
    tx_d = tx_q;
    case (tx_q)
      TX_IDLE: if (tx_req) tx_d = cts_ok ? TX_GNT : TX_HOLD;
      TX_HOLD: begin
        if (!tx_req)     tx_d = TX_IDLE;
        else if (cts_ok) tx_d = TX_GNT;
      end
      TX_GNT:  tx_d = TX_WAIT;
      TX_WAIT: if (!tx_req) tx_d = TX_IDLE;
      default: tx_d = TX_IDLE;
    endcase
  end

  assign nDTR      = loop | ~dtr;
  assign nRTS      = loop | ~(rts & rts_ok);
  assign OUT1      = loop | ~out1;
  assign OUT2      = loop | ~out2;
  assign mcr       = mcr_q;
  assign msr       = {stat_q, delta_q};
  assign modem_irq = irq_q;
  assign tx_gnt    = gnt_q;

endmodule
